x_bus_ctrl_rv32i: RTL and testbench
===================================

// Module: x_bus_ctrl_rv32i
// PURPOSE
//   Downstream memory-side controller for the rv32i core's single-request bus (valid/rnw/addr/data,
//   accept/rdata). Decodes each request to a word-addressed sync SRAM or to a small register bank:
//   GPIO out, free-running timer, error status. Responds with a one-cycle accept carrying read data.
// PARAMETERS
//   RAM_AW       10             SRAM word-address width (RAM = 4*2^RAM_AW bytes at 0x0000_0000)
//   GPIO_W       8              width of o_gpio (1..32)
//   PERIPH_BASE  32'h8000_0000  base of register bank (bits [3:0] must be 0)
// PORTS
//   i_clk        in   1        clock
//   i_nrst       in   1        reset, asynchronous, active-low
//   i_valid      in   1        core request valid; held with addr/rnw/data until o_accept
//   i_rnw        in   1        1 = read, 0 = write
//   i_addr       in   32       byte address; [1:0] ignored (word access only)
//   i_data       in   32       write data
//   o_accept     out  1        one-cycle response strobe; request complete
//   o_data       out  32       read data, valid only when o_accept=1 (0 otherwise)
//   o_ram_en     out  1        SRAM access strobe (registered)
//   o_ram_we     out  1        SRAM write enable, qualified by o_ram_en
//   o_ram_addr   out  RAM_AW   SRAM word address = i_addr[RAM_AW+1:2]
//   o_ram_wdata  out  32       SRAM write data
//   i_ram_rdata  in   32       SRAM read data, valid cycle after o_ram_en (1-cycle sync read)
//   o_gpio       out  GPIO_W   GPIO output register
//   o_err        out  1        sticky unmapped-access flag
// BEHAVIOUR
//   Reset: state IDLE; o_accept, o_data, o_ram_*, o_gpio, o_err, timer all 0.
//   Request regs (rnw, addr, wdata, target) captured in IDLE when i_valid=1; never re-sampled
//   until back in IDLE. Request input is ignored in all other states.
//   Decode: RAM hit  = i_addr[31:RAM_AW+2]==0.
//           REG hit  = i_addr[31:4]==PERIPH_BASE[31:4]; [3:2]: 0 GPIO(RW), 1 TIMER(RW), 2 STATUS.
//           [3:2]==3, or neither hit -> UNMAPPED.
//   FSM: IDLE -(i_valid & RAM)-> RAM_ACC -> RESP -> IDLE
//        IDLE -(i_valid & REG/UNMAPPED)-> REG_ACC -> RESP -> IDLE ; else stay IDLE.
//   Latency fixed: request first seen in cycle 0, o_accept=1 in cycle 2; max 1 request/3 cycles.
//   RAM_ACC: o_ram_en=1, o_ram_we=~rnw, addr/wdata from capture regs; exactly one strobe per request.
//   RESP: o_accept=1; o_data = i_ram_rdata (RAM read), rdata reg (REG read), 0 for writes.
//   REG_ACC (update at edge ending REG_ACC, visible in RESP):
//     GPIO   write: o_gpio <= wdata[GPIO_W-1:0]; read: zero-extended o_gpio.
//     TIMER  32b, +1 every cycle, wraps FFFF_FFFF->0; write loads wdata (write wins over
//            increment that cycle); read returns value during REG_ACC.
//     STATUS read: {31'b0,o_err}; write (any data): clears o_err.
//     UNMAPPED read returns 0; write dropped; o_err <= 1 (sticky until STATUS write or reset).
//   Core advances on o_accept, so a new request appears at earliest in the IDLE cycle after RESP;
//   no request is lost or duplicated.
//   Async reset mid-transaction aborts: back to IDLE, pending request dropped, no RAM strobe.
// TESTING
//   1 i_nrst low with i_valid=1,addr=0 -> all outputs 0; after release: o_ram_en cycle 1 (addr 0,
//     we 0), o_accept cycle 2 with o_data = SRAM model word 0.
//   2 Write 0x1234_5678 @0x10 then read @0x10 -> o_ram_we=1, o_ram_addr=4 once; read returns
//     0x1234_5678; o_accept exactly once per request.
//   3 Write 0x0000_01A5 @0x8000_0000 -> o_gpio=0xA5 in RESP cycle; read back returns 0x0000_00A5.
//   4 Write 0xFFFF_FFFF @0x8000_0004, next read @0x8000_0004 issued in following IDLE -> returns
//     0x0000_0001 (wrap through 0).
//   5 Read @0x4000_0000 -> o_data 0, o_err=1; read @0x8000_000C -> 0, o_err stays 1; read STATUS
//     -> 1; write STATUS -> o_err=0.
//   6 Assert i_nrst low in RAM_ACC of a write -> no further o_ram_en/o_accept; after release,
//     held request is re-issued and completes with one write only.

Source files
------------

// File: rtl/x_bus_ctrl_rv32i.sv
// Memory-side controller for the rv32i single-request bus: decodes each request to a
// word-addressed sync SRAM or a small register bank (GPIO, timer, status) with fixed 2-cycle latency.
module x_bus_ctrl_rv32i #(
    parameter int unsigned RAM_AW      = 10,
    parameter int unsigned GPIO_W      = 8,
    parameter logic [31:0] PERIPH_BASE = 32'h8000_0000
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_valid,
    input  logic              i_rnw,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_data,
    output logic              o_accept,
    output logic [31:0]       o_data,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic [31:0]       o_ram_wdata,
    input  logic [31:0]       i_ram_rdata,
    output logic [GPIO_W-1:0] o_gpio,
    output logic              o_err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RAM_ACC = 2'd1;
    localparam logic [1:0] S_REG_ACC = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    localparam logic [1:0] SEL_GPIO   = 2'd0;
    localparam logic [1:0] SEL_TIMER  = 2'd1;
    localparam logic [1:0] SEL_STATUS = 2'd2;
    localparam logic [1:0] SEL_UNMAP  = 2'd3;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              rnw_q;
    logic              ram_q;
    logic [1:0]        sel_q;
    logic [RAM_AW-1:0] ram_addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [31:0]       timer_q;
    logic [GPIO_W-1:0] gpio_q;
    logic              err_q;

    logic              ram_hit_c;
    logic              reg_hit_c;
    logic [1:0]        sel_c;
    logic              capture_c;
    logic              unused_addr_lsb;

    // Byte-lane bits are meaningless for word-only access.
    assign unused_addr_lsb = ^i_addr[1:0];

    // Address decode; word offset 3 inside the bank falls through to unmapped.
    assign ram_hit_c = (i_addr >> (RAM_AW + 32'd2)) == 32'd0;
    assign reg_hit_c = i_addr[31:4] == PERIPH_BASE[31:4];
    assign sel_c     = reg_hit_c ? i_addr[3:2] : SEL_UNMAP;
    assign capture_c = (state_q == S_IDLE) && i_valid;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    state_d = ram_hit_c ? S_RAM_ACC : S_REG_ACC;
                end
            end
            S_RAM_ACC: state_d = S_RESP;
            S_REG_ACC: state_d = S_RESP;
            default:   state_d = S_IDLE;
        endcase
    end

    // Request is latched once in IDLE and held until the next IDLE.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            rnw_q      <= 1'b0;
            ram_q      <= 1'b0;
            sel_q      <= SEL_GPIO;
            ram_addr_q <= '0;
            wdata_q    <= '0;
        end else if (capture_c) begin
            rnw_q      <= i_rnw;
            ram_q      <= ram_hit_c;
            sel_q      <= sel_c;
            ram_addr_q <= i_addr[RAM_AW+1:2];
            wdata_q    <= i_data;
        end
    end

    // Register bank; timer free-runs, a timer write in REG_ACC overrides the increment.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            timer_q <= '0;
            gpio_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            timer_q <= timer_q + 32'd1;
            if (state_q == S_REG_ACC) begin
                rdata_q <= '0;
                case (sel_q)
                    SEL_GPIO: begin
                        if (rnw_q) rdata_q <= 32'(gpio_q);
                        else       gpio_q  <= wdata_q[GPIO_W-1:0];
                    end
                    SEL_TIMER: begin
                        if (rnw_q) rdata_q <= timer_q;
                        else       timer_q <= wdata_q;
                    end
                    SEL_STATUS: begin
                        if (rnw_q) rdata_q <= {31'd0, err_q};
                        else       err_q   <= 1'b0;
                    end
                    default: err_q <= 1'b1;
                endcase
            end
        end
    end

    assign o_accept    = state_q == S_RESP;
    assign o_data      = (o_accept && rnw_q) ? (ram_q ? i_ram_rdata : rdata_q) : 32'd0;
    assign o_ram_en    = state_q == S_RAM_ACC;
    assign o_ram_we    = o_ram_en && !rnw_q;
    assign o_ram_addr  = ram_addr_q;
    assign o_ram_wdata = wdata_q;
    assign o_gpio      = gpio_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_x_bus_ctrl_rv32i.sv
// Self-checking bench for x_bus_ctrl_rv32i: directed table, reset corner cases and
// randomized requests against a transaction-level reference model.
module tb_x_bus_ctrl_rv32i;

    localparam int unsigned RAM_AW = 10;
    localparam int unsigned GPIO_W = 8;
    localparam logic [31:0] PB     = 32'h8000_0000;

    logic              clk;
    logic              nrst;
    logic              valid;
    logic              rnw;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              accept;
    logic [31:0]       rdata;
    logic              ram_en;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [GPIO_W-1:0] gpio;
    logic              err;

    x_bus_ctrl_rv32i #(.RAM_AW(RAM_AW), .GPIO_W(GPIO_W), .PERIPH_BASE(PB)) dut (
        .i_clk(clk), .i_nrst(nrst), .i_valid(valid), .i_rnw(rnw), .i_addr(addr),
        .i_data(wdata), .o_accept(accept), .o_data(rdata), .o_ram_en(ram_en),
        .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
        .i_ram_rdata(ram_rdata), .o_gpio(gpio), .o_err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment SRAM with one-cycle synchronous read.
    logic [31:0] sram [0:1023];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) sram[ram_addr] <= ram_wdata;
            ram_rdata <= sram[ram_addr];
        end
    end

    // Cycles since reset release; the timer model is expressed against this count.
    logic [31:0] cyc;
    always @(posedge clk or negedge nrst) begin
        if (!nrst) cyc <= 32'd0;
        else       cyc <= cyc + 32'd1;
    end

    // Reference model state.
    logic [31:0] mem_m [0:1023];
    logic [7:0]  gpio_m;
    logic        err_m;
    logic [31:0] tbase_val;
    logic [31:0] tbase_cyc;

    int n_tests;
    int n_fail;

    typedef struct {
        logic        rnw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [7:0]  exp_gpio;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // 0 RAM, 1 GPIO, 2 TIMER, 3 STATUS, 4 unmapped
    function automatic int region(input logic [31:0] a);
        if (a < 32'd4096) return 0;
        if (a >= PB && a < PB + 32'd12) return 1 + int'((a - PB) >> 2);
        return 4;
    endfunction

    task automatic model_reset();
        gpio_m    = 8'd0;
        err_m     = 1'b0;
        tbase_val = 32'd0;
        tbase_cyc = 32'd0;
    endtask

    // Expected read data for a request first seen in cycle c0, then apply its side effects.
    task automatic model_apply(input logic r, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] c0, output logic [31:0] exp);
        int rg;
        rg  = region(a);
        exp = 32'd0;
        case (rg)
            0: begin
                if (r) exp = mem_m[a >> 2];
                else   mem_m[a >> 2] = d;
            end
            1: begin
                if (r) exp = {24'd0, gpio_m};
                else   gpio_m = d[7:0];
            end
            2: begin
                if (r) exp = tbase_val + (c0 + 32'd1 - tbase_cyc);
                else begin
                    tbase_val = d;
                    tbase_cyc = c0 + 32'd2;
                end
            end
            3: begin
                if (r) exp = {31'd0, err_m};
                else   err_m = 1'b0;
            end
            default: err_m = 1'b1;
        endcase
    endtask

    // Wait (bounded) for o_accept, recording SRAM strobes along the way.
    task automatic wait_resp(output int lat, output int strobes, output logic s_we,
                             output logic [RAM_AW-1:0] s_addr, output logic [31:0] s_wd,
                             output logic [31:0] d);
        lat = -1; strobes = 0; s_we = 1'b0; s_addr = '0; s_wd = '0; d = '0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (ram_en) begin
                strobes++;
                s_we = ram_we; s_addr = ram_addr; s_wd = ram_wdata;
            end
            if (accept) begin
                lat = k;
                d   = rdata;
                break;
            end
        end
    endtask

    task automatic run_req(input string nm, input logic r, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] got);
        logic [31:0] c0, exp;
        int lat, strobes, rg;
        logic s_we;
        logic [RAM_AW-1:0] s_addr;
        logic [31:0] s_wd;
        @(posedge clk); #1;
        chk({nm, "_idle_accept"}, {31'd0, accept}, 32'd0);
        chk({nm, "_idle_data"}, rdata, 32'd0);
        c0 = cyc;
        rg = region(a);
        valid = 1'b1; rnw = r; addr = a; wdata = d;
        wait_resp(lat, strobes, s_we, s_addr, s_wd, got);
        valid = 1'b0;
        model_apply(r, a, d, c0, exp);
        chk({nm, "_latency"}, 32'(lat), 32'd2);
        chk({nm, "_strobes"}, 32'(strobes), (rg == 0) ? 32'd1 : 32'd0);
        if (rg == 0) begin
            chk({nm, "_ram_we"}, {31'd0, s_we}, {31'd0, ~r});
            chk({nm, "_ram_addr"}, 32'(s_addr), a >> 2);
            if (!r) chk({nm, "_ram_wdata"}, s_wd, d);
        end
        chk({nm, "_data"}, got, exp);
        chk({nm, "_gpio"}, 32'(gpio), {24'd0, gpio_m});
        chk({nm, "_err"}, {31'd0, err}, {31'd0, err_m});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got, old, d, a;
        int lat, strobes, bad;
        logic s_we;
        logic [RAM_AW-1:0] s_addr;
        logic [31:0] s_wd;

        n_tests = 0; n_fail = 0;
        tbl[0] = '{1'b0, 32'h0000_0010, 32'h1234_5678, 32'h0000_0000, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 32'h0000_0010, 32'h0000_0000, 32'h1234_5678, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 32'h8000_0000, 32'h0000_01A5, 32'h0000_0000, 1'b0, 8'hA5};
        tbl[3] = '{1'b1, 32'h8000_0000, 32'h0000_0000, 32'h0000_00A5, 1'b0, 8'hA5};
        tbl[4] = '{1'b0, 32'h8000_0004, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 8'hA5};
        tbl[5] = '{1'b1, 32'h8000_0004, 32'h0000_0000, 32'h0000_0001, 1'b0, 8'hA5};
        tbl[6] = '{1'b1, 32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 8'hA5};
        tbl[7] = '{1'b1, 32'h8000_000C, 32'h0000_0000, 32'h0000_0000, 1'b1, 8'hA5};
        tbl[8] = '{1'b1, 32'h8000_0008, 32'h0000_0000, 32'h0000_0001, 1'b1, 8'hA5};
        tbl[9] = '{1'b0, 32'h8000_0008, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 8'hA5};

        for (int i = 0; i < 1024; i++) begin
            sram[i]  = $urandom();
            mem_m[i] = sram[i];
        end
        ram_rdata = 32'd0;
        model_reset();

        // Reset held with a pending read of word 0.
        nrst = 1'b0; valid = 1'b1; rnw = 1'b1; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_accept", {31'd0, accept}, 32'd0);
        chk("rst_data", rdata, 32'd0);
        chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_gpio", 32'(gpio), 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        wait_resp(lat, strobes, s_we, s_addr, s_wd, got);
        valid = 1'b0;
        chk("t1_latency", 32'(lat), 32'd2);
        chk("t1_strobes", 32'(strobes), 32'd1);
        chk("t1_ram_we", {31'd0, s_we}, 32'd0);
        chk("t1_ram_addr", 32'(s_addr), 32'd0);
        chk("t1_data", got, mem_m[0]);

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            run_req($sformatf("tbl%0d", i), tbl[i].rnw, tbl[i].addr, tbl[i].wdata, got);
            chk($sformatf("tbl%0d_vec_data", i), got, tbl[i].exp_data);
            chk($sformatf("tbl%0d_vec_err", i), {31'd0, err}, {31'd0, tbl[i].exp_err});
            chk($sformatf("tbl%0d_vec_gpio", i), 32'(gpio), {24'd0, tbl[i].exp_gpio});
        end

        // Randomized traffic with idle gaps.
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 2))
                0: a = 32'($urandom_range(0, 1023)) * 32'd4 + 32'($urandom_range(0, 3));
                1: a = PB + 32'($urandom_range(0, 15));
                default: begin
                    a = $urandom();
                    if (a < 32'd4096 || (a >= PB && a < PB + 32'd16)) a = 32'h4000_0000;
                end
            endcase
            run_req($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, $urandom(), got);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // Reset asserted during RAM_ACC of a write; the held request is reissued after release.
        @(posedge clk); #1;
        old = sram[8];
        d   = ~old;
        valid = 1'b1; rnw = 1'b0; addr = 32'h0000_0020; wdata = d;
        @(posedge clk); #1;
        chk("t6_ram_acc", {31'd0, ram_en}, 32'd1);
        #2 nrst = 1'b0;
        #1;
        chk("t6_abort_en", {31'd0, ram_en}, 32'd0);
        chk("t6_abort_acc", {31'd0, accept}, 32'd0);
        bad = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (ram_en || accept) bad++;
        end
        chk("t6_quiet_in_reset", 32'(bad), 32'd0);
        chk("t6_no_write", sram[8], old);
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        wait_resp(lat, strobes, s_we, s_addr, s_wd, got);
        valid = 1'b0;
        mem_m[8] = d;
        chk("t6_latency", 32'(lat), 32'd2);
        chk("t6_strobes", 32'(strobes), 32'd1);
        chk("t6_ram_we", {31'd0, s_we}, 32'd1);
        chk("t6_written", sram[8], d);
        @(posedge clk); #1;
        chk("t6_single_accept", {31'd0, accept}, 32'd0);
        run_req("t6_readback", 1'b1, 32'h0000_0020, 32'd0, got);
        run_req("t6_timer", 1'b1, PB + 32'd4, 32'd0, got);
        run_req("t6_gpio", 1'b1, PB, 32'd0, got);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
